// File: rtl/lane_swap_pipe_if.sv
// lane_swap_pipe_if: valid/ready bus into and out of the lane permutation stage.
//   in_valid/in_ready/in_data/in_mode : upstream beat; in_mode travels with in_data
//   out_valid/out_ready/out_data      : downstream beat
// Modports:
//   slave  : the permutation stage
//   master : whoever drives the stage, such as a bench or surrounding glue
interface lane_swap_pipe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [1:0]             in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lane_swap_pipe.sv
// lane_swap_pipe: registered lane permutation with a one-entry skid buffer.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : lane_swap_pipe_if.slave (in_* upstream, out_* downstream)
//   xfer_count : completed output handshakes, wrapping at 2^CNT_W
// Modes: 0 pass, 1 adjacent-pair swap, 2 rotate down by one lane, 3 reverse.
// The permutation is applied before the beat is registered, so both the main
// and the skid register hold already-permuted words.

// One output lane: selects its source lane for the given mode.
module lane_swap_mux #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int J     = 0
) (
  input  logic [LANES-1:0][WIDTH-1:0] lanes,
  input  logic [1:0]                  mode,
  output logic [WIDTH-1:0]            lane_out
);
  localparam int SWP = J ^ 1;
  localparam int ROT = (J + 1) % LANES;
  localparam int REV = LANES - 1 - J;

  always_comb begin
    lane_out = lanes[J];
    case (mode)
      2'd0: lane_out = lanes[J];
      2'd1: lane_out = lanes[SWP];
      2'd2: lane_out = lanes[ROT];
      2'd3: lane_out = lanes[REV];
    endcase
  end
endmodule

module lane_swap_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lane_swap_pipe_if.slave  bus,
  output logic [CNT_W-1:0] xfer_count
);
  logic [LANES-1:0][WIDTH-1:0] in_lanes;
  logic [LANES-1:0][WIDTH-1:0] perm;
  logic [LANES-1:0][WIDTH-1:0] main_data;
  logic [LANES-1:0][WIDTH-1:0] skid_data;
  logic                        main_valid;
  logic                        skid_valid;
  logic                        acc;
  logic                        drn;

  assign in_lanes = bus.in_data;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    lane_swap_mux #(.WIDTH(WIDTH), .LANES(LANES), .J(j)) u_mux (
      .lanes    (in_lanes),
      .mode     (bus.in_mode),
      .lane_out (perm[j])
    );
  end

  // in_ready comes straight from the skid flag, so out_ready never reaches
  // the upstream side combinationally.
  assign acc = bus.in_valid & ~skid_valid;
  assign drn = main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      xfer_count <= '0;
    end else begin
      if (!main_valid || drn) begin
        // Main register is free this cycle: a skid entry has priority, since
        // acc is impossible while the skid is occupied.
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (acc) begin
          main_data  <= perm;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (acc) begin
        // Main is stalled; park the new beat so the upstream side saw no bubble.
        skid_data  <= perm;
        skid_valid <= 1'b1;
      end
      if (drn) xfer_count <= xfer_count + 1'b1;
    end
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
endmodule

// File: tb/tb_lane_swap_pipe.sv
module tb_lane_swap_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lane_swap_pipe_if #(.WIDTH(8), .LANES(2)) if2 ();
  lane_swap_pipe_if #(.WIDTH(8), .LANES(4)) if4 ();
  logic [15:0] cnt2;
  logic [3:0]  cnt4;

  lane_swap_pipe #(.WIDTH(8), .LANES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .xfer_count(cnt2));
  lane_swap_pipe #(.WIDTH(8), .LANES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .xfer_count(cnt4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Everything happens 1 time unit after a rising edge: inputs change and
  // outputs are sampled well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mode_exp [4];

  initial begin
    mode_exp[0] = 32'h44332211;
    mode_exp[1] = 32'h33441122;
    mode_exp[2] = 32'h11443322;
    mode_exp[3] = 32'h11223344;

    if2.in_valid = 0; if2.in_data = '0; if2.in_mode = 0; if2.out_ready = 1;
    if4.in_valid = 0; if4.in_data = '0; if4.in_mode = 0; if4.out_ready = 1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_out_valid2", {31'd0, if2.out_valid}, 0);
    chk("rst_in_ready2",  {31'd0, if2.in_ready}, 1);
    chk("rst_out_data2",  {16'd0, if2.out_data}, 0);
    chk("rst_cnt2",       {16'd0, cnt2}, 0);
    chk("rst_out_valid4", {31'd0, if4.out_valid}, 0);
    chk("rst_cnt4",       {28'd0, cnt4}, 0);

    // basic swap on two lanes: lane1=200, lane0=123
    if2.in_valid = 1; if2.in_data = {8'd200, 8'd123}; if2.in_mode = 2'd1;
    tick();
    if2.in_valid = 0;
    chk("swap_valid", {31'd0, if2.out_valid}, 1);
    chk("swap_data",  {16'd0, if2.out_data}, {16'd0, 8'd123, 8'd200});
    chk("swap_cnt0",  {16'd0, cnt2}, 0);
    tick();
    chk("swap_valid_drop", {31'd0, if2.out_valid}, 0);
    chk("swap_cnt1",       {16'd0, cnt2}, 1);

    // all four modes back to back on four lanes
    if4.in_valid = 1; if4.in_data = 32'h44332211;
    for (int m = 0; m < 4; m++) begin
      if4.in_mode = 2'(m);
      tick();
      chk($sformatf("mode%0d_valid", m), {31'd0, if4.out_valid}, 1);
      chk($sformatf("mode%0d_data", m), if4.out_data, mode_exp[m]);
    end
    if4.in_valid = 0;
    tick();
    chk("modes_idle", {31'd0, if4.out_valid}, 0);
    chk("modes_cnt",  {28'd0, cnt4}, 4);

    // backpressure: A stalls, B goes to skid, C is refused
    if4.out_ready = 0;
    if4.in_valid = 1; if4.in_data = 32'hA0A1A2A3; if4.in_mode = 2'd0;
    tick();
    chk("bp_a_data",   if4.out_data, 32'hA0A1A2A3);
    chk("bp_a_ready",  {31'd0, if4.in_ready}, 1);
    if4.in_data = 32'hB0B1B2B3; if4.in_mode = 2'd3;
    tick();
    chk("bp_b_ready",  {31'd0, if4.in_ready}, 0);
    chk("bp_a_hold1",  if4.out_data, 32'hA0A1A2A3);
    if4.in_data = 32'hC0C1C2C3; if4.in_mode = 2'd1;
    tick();
    chk("bp_c_ready",  {31'd0, if4.in_ready}, 0);
    chk("bp_a_hold2",  if4.out_data, 32'hA0A1A2A3);
    chk("bp_a_valid",  {31'd0, if4.out_valid}, 1);
    tick();
    chk("bp_a_hold3",  if4.out_data, 32'hA0A1A2A3);
    chk("bp_cnt_hold", {28'd0, cnt4}, 4);
    if4.out_ready = 1;
    tick();
    chk("bp_b_data",   if4.out_data, 32'hB3B2B1B0);
    chk("bp_b_rdy",    {31'd0, if4.in_ready}, 1);
    chk("bp_cnt5",     {28'd0, cnt4}, 5);
    tick();
    if4.in_valid = 0;
    chk("bp_c_data",   if4.out_data, 32'hC1C0C3C2);
    chk("bp_cnt6",     {28'd0, cnt4}, 6);
    tick();
    chk("bp_empty",    {31'd0, if4.out_valid}, 0);
    chk("bp_cnt7",     {28'd0, cnt4}, 7);

    // reset mid-stream from FULL
    if4.out_ready = 0; if4.in_valid = 1; if4.in_data = 32'h01020304; if4.in_mode = 2'd0;
    tick(); tick();
    chk("full_ready", {31'd0, if4.in_ready}, 0);
    if4.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("amid_valid", {31'd0, if4.out_valid}, 0);
    chk("amid_ready", {31'd0, if4.in_ready}, 1);
    chk("amid_cnt",   {28'd0, cnt4}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, if4.out_valid}, 0);

    // counter wrap over 17 handshakes; first beat also checks post-reset latency
    if4.out_ready = 1; if4.in_valid = 1; if4.in_data = 32'h0D0C0B0A; if4.in_mode = 2'd2;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) if4.in_valid = 0;
      if (k == 1) begin
        chk("lat_valid", {31'd0, if4.out_valid}, 1);
        chk("lat_data",  if4.out_data, 32'h0A0D0C0B);
        chk("lat_cnt",   {28'd0, cnt4}, 0);
      end
      if (k >= 16) chk($sformatf("wrap_cnt_k%0d", k), {28'd0, cnt4}, 32'((k - 1) & 15));
    end
    chk("wrap_done_valid", {31'd0, if4.out_valid}, 0);

    // idle hold
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle_valid%0d", i), {31'd0, if4.out_valid}, 0);
      chk($sformatf("idle_cnt%0d", i),   {28'd0, cnt4}, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
